// File: rtl/bcd_stopwatch_if.sv
// Button inputs and display outputs of the BCD stopwatch.
// The master side presses the buttons and the slave side drives the display.
interface bcd_stopwatch_if;
    logic       start_stop;
    logic       lap;
    logic       clear;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic       running;
    logic       lap_active;
    logic       wrap;

    modport master (
        output start_stop, lap, clear,
        input  digit0, digit1, digit2, digit3, running, lap_active, wrap
    );

    modport slave (
        input  start_stop, lap, clear,
        output digit0, digit1, digit2, digit3, running, lap_active, wrap
    );
endinterface

// File: rtl/bcd_stopwatch.sv
// Four-digit BCD stopwatch (SS.hh, 00.00-59.99) with start/stop, lap and clear buttons.
// Produces a 100 Hz tick from the board clock and feeds the seven-segment decoders.
module bcd_stopwatch #(
    parameter int TICK_DIV = 500000
) (
    input  logic            clk,
    input  logic            rst,
    bcd_stopwatch_if.slave  bus
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    localparam logic [1:0] ST_STOPPED = 2'd0;
    localparam logic [1:0] ST_RUNNING = 2'd1;
    localparam logic [1:0] ST_LAP     = 2'd2;

    // Bit order in the button vectors: {clear, lap, start_stop}
    logic [2:0] btn_s1, btn_s2, btn_h, btn_ev;
    logic       ev_ss, ev_lap, ev_clr;

    logic [1:0]    state, state_nxt;
    logic [PW-1:0] pre;
    logic          counting, tick, zero_cnt;

    logic [3:0] d0_p0, d1_p0, d2_p0, d3_p0;
    logic [3:0] d0_p1, d1_p1, d2_p1, d3_p1;
    logic       wrap_p0, wrap_p1;
    logic [4:0] s0, s1, s2, s3;

    // Returns {carry_out, next_digit}; the digit only moves when carry_in is set.
    function automatic logic [4:0] bcd_step(input logic [3:0] d, input logic [3:0] last,
                                            input logic cin);
        if (!cin)
            return {1'b0, d};
        if (d == last)
            return {1'b1, 4'd0};
        return {1'b0, d + 4'd1};
    endfunction

    assign btn_ev = btn_s2 & ~btn_h;
    assign ev_ss  = btn_ev[0];
    assign ev_lap = btn_ev[1];
    assign ev_clr = btn_ev[2];

    assign counting = (state != ST_STOPPED);
    assign tick     = counting && (pre == PRE_LAST);
    assign zero_cnt = (state == ST_STOPPED) && ev_clr;

    always_comb begin
        s0 = bcd_step(d0_p0, 4'd9, tick);
        s1 = bcd_step(d1_p0, 4'd9, s0[4]);
        s2 = bcd_step(d2_p0, 4'd9, s1[4]);
        s3 = bcd_step(d3_p0, 4'd5, s2[4]);
    end

    // start_stop takes priority over lap whenever both arrive together
    always_comb begin
        state_nxt = state;
        case (state)
            ST_STOPPED: if (ev_ss) state_nxt = ST_RUNNING;
            ST_RUNNING: begin
                if (ev_ss)       state_nxt = ST_STOPPED;
                else if (ev_lap) state_nxt = ST_LAP;
            end
            ST_LAP: begin
                if (ev_ss)       state_nxt = ST_STOPPED;
                else if (ev_lap) state_nxt = ST_RUNNING;
            end
            default: state_nxt = ST_STOPPED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s1  <= '0;
            btn_s2  <= '0;
            btn_h   <= '0;
            state   <= ST_STOPPED;
            pre     <= '0;
            d0_p0   <= '0;
            d1_p0   <= '0;
            d2_p0   <= '0;
            d3_p0   <= '0;
            wrap_p0 <= 1'b0;
            d0_p1   <= '0;
            d1_p1   <= '0;
            d2_p1   <= '0;
            d3_p1   <= '0;
            wrap_p1 <= 1'b0;
        end else begin
            btn_s1 <= {bus.clear, bus.lap, bus.start_stop};
            btn_s2 <= btn_s1;
            btn_h  <= btn_s2;
            state  <= state_nxt;

            // Prescaler holds while stopped so the sub-tick phase survives stop/start
            if (zero_cnt)
                pre <= '0;
            else if (tick)
                pre <= '0;
            else if (counting)
                pre <= pre + 1'b1;

            // Stage p0: live count
            if (zero_cnt) begin
                d0_p0 <= '0;
                d1_p0 <= '0;
                d2_p0 <= '0;
                d3_p0 <= '0;
            end else begin
                d0_p0 <= s0[3:0];
                d1_p0 <= s1[3:0];
                d2_p0 <= s2[3:0];
                d3_p0 <= s3[3:0];
            end
            wrap_p0 <= s3[4];

            // Stage p1: display register, frozen while in LAP
            if (state != ST_LAP) begin
                d0_p1 <= d0_p0;
                d1_p1 <= d1_p0;
                d2_p1 <= d2_p0;
                d3_p1 <= d3_p0;
            end
            wrap_p1 <= wrap_p0;
        end
    end

    assign bus.digit0     = d0_p1;
    assign bus.digit1     = d1_p1;
    assign bus.digit2     = d2_p1;
    assign bus.digit3     = d3_p1;
    assign bus.wrap       = wrap_p1;
    assign bus.running    = (state == ST_RUNNING) || (state == ST_LAP);
    assign bus.lap_active = (state == ST_LAP);
endmodule

// File: tb/tb_bcd_stopwatch.sv
// Scoreboard bench for bcd_stopwatch: an integer-count reference model queues the
// expected display each cycle and a monitor compares the DUT against it.
module tb_bcd_stopwatch;
    localparam int TD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    bcd_stopwatch_if bus ();

    bcd_stopwatch #(.TICK_DIV(TD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] digits;
        logic        run;
        logic        lapa;
        logic        wrap;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: count held as hundredths 0..5999, phase as 0..TD-1
    int m_st = 0;     // 0 stopped, 1 running, 2 lap
    int m_cnt = 0, m_phase = 0, m_disp = 0;
    bit m_wpend = 0, m_wrap = 0;
    bit hs[3], hl[3], hc[3];

    always @(posedge clk) begin
        bit evs, evl, evc, cnt_on, tk;
        exp_t e;
        if (rst) begin
            m_st = 0; m_cnt = 0; m_phase = 0; m_disp = 0; m_wpend = 0; m_wrap = 0;
            for (int i = 0; i < 3; i++) begin hs[i] = 0; hl[i] = 0; hc[i] = 0; end
        end else begin
            // A level change seen at edge m acts on the state at edge m+2
            evs = hs[1] && !hs[2];
            evl = hl[1] && !hl[2];
            evc = hc[1] && !hc[2];
            cnt_on = (m_st != 0);
            tk = cnt_on && (m_phase == TD - 1);
            m_wrap  = m_wpend;
            m_wpend = tk && (m_cnt == 5999);
            if (m_st != 2) m_disp = m_cnt;
            if (tk) m_cnt = (m_cnt + 1) % 6000;
            if (cnt_on) m_phase = (m_phase + 1) % TD;
            case (m_st)
                0: begin
                    if (evc) begin m_cnt = 0; m_phase = 0; end
                    if (evs) m_st = 1;
                end
                1: if (evs) m_st = 0; else if (evl) m_st = 2;
                default: if (evs) m_st = 0; else if (evl) m_st = 1;
            endcase
            hs[2] = hs[1]; hs[1] = hs[0]; hs[0] = bus.start_stop;
            hl[2] = hl[1]; hl[1] = hl[0]; hl[0] = bus.lap;
            hc[2] = hc[1]; hc[1] = hc[0]; hc[0] = bus.clear;
        end
        e.digits = {4'(m_disp / 1000), 4'((m_disp / 100) % 10),
                    4'((m_disp / 10) % 10), 4'(m_disp % 10)};
        e.run  = (m_st != 0);
        e.lapa = (m_st == 2);
        e.wrap = m_wrap;
        exp_q.push_back(e);
    end

    // Monitor: the DUT presents a new display every cycle
    always @(negedge clk) begin
        exp_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a.digits = {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
            a.run  = bus.running;
            a.lapa = bus.lap_active;
            a.wrap = bus.wrap;
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL display t=%0t actual digits=%h run=%b lap=%b wrap=%b required digits=%h run=%b lap=%b wrap=%b",
                         $time, a.digits, a.run, a.lapa, a.wrap, e.digits, e.run, e.lapa, e.wrap);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit ss, input bit lp, input bit cl, input int hold);
        @(negedge clk);
        bus.start_stop = ss;
        bus.lap        = lp;
        bus.clear      = cl;
        repeat (hold) @(negedge clk);
        bus.start_stop = 1'b0;
        bus.lap        = 1'b0;
        bus.clear      = 1'b0;
    endtask

    initial begin
        bus.start_stop = 1'b0;
        bus.lap        = 1'b0;
        bus.clear      = 1'b0;
        idle(3);
        rst = 1'b0;
        idle(3);

        // Start and count through the first digit1 carry
        press(1, 0, 0, 3);
        idle(50);
        // Full minute including the 59.99 -> 00.00 wrap
        idle(24100);

        // Stop, hold, restart with preserved phase
        press(1, 0, 0, 1);
        idle(100);
        press(1, 0, 0, 2);
        idle(30);
        // Lap freeze and release
        press(0, 1, 0, 1);
        idle(200);
        press(0, 1, 0, 1);
        idle(30);
        // Clear while running has no effect; clear while stopped zeroes
        press(0, 0, 1, 2);
        idle(10);
        press(1, 0, 0, 1);
        idle(7);
        press(0, 0, 1, 1);
        idle(10);
        // start_stop + clear while stopped
        press(1, 0, 1, 1);
        idle(23);
        // start_stop + lap while running -> stopped
        press(1, 1, 0, 1);
        idle(10);
        press(1, 0, 0, 1);
        idle(5);
        press(0, 1, 0, 1);
        idle(10);
        // start_stop + lap while in lap -> stopped, display live again
        press(1, 1, 0, 1);
        idle(10);

        // Random button traffic
        for (int i = 0; i < 80; i++) begin
            int unsigned sel;
            sel = $urandom_range(0, 5);
            case (sel)
                0, 1: press(1, 0, 0, $urandom_range(1, 4));
                2:    press(0, 1, 0, $urandom_range(1, 4));
                3:    press(0, 0, 1, $urandom_range(1, 4));
                4:    press(1, 0, 1, 1);
                default: press(1, 1, 0, 1);
            endcase
            idle($urandom_range(1, 60));
        end

        // Get running, then reset mid-run with start_stop held through reset
        press(1, 0, 0, 1);
        idle(500);
        @(negedge clk);
        bus.start_stop = 1'b1;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(6);
        bus.start_stop = 1'b0;
        idle(60);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0 || checks < 1000) begin
            errors++;
            $display("FAIL drain actual pending=%0d checks=%0d required pending=0 checks>=1000",
                     exp_q.size(), checks);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
